// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding and array instruction constants for the mac_array sequencer.
package mac_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LWAIT, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
endpackage

// File: rtl/mac_ctrl_counter.sv
// Loadable up-counter with clear, enable and terminal compare on the current value.
module mac_ctrl_counter
  import mac_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_load) r_cnt <= i_ld_val;
    else if (i_en)   r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);
endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the weight-stationary mac_array: kernel load, skew settle, activation stream, drain.
// MAC_ARRAY_CTRL_PERF_EN adds busy-cycle and EXEC-stall performance counters.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int ADDR_BW = 11,
  parameter int LEN_BW  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_BW-1:0] i_w_base,
  input  logic [ADDR_BW-1:0] i_x_base,
  input  logic [LEN_BW-1:0]  i_num_vec,
  input  logic               i_ofifo_full,
  input  logic [COL-1:0]     i_valid,
  output logic               o_mem_cen,
  output logic [ADDR_BW-1:0] o_mem_addr,
  output logic [1:0]         o_inst_w,
  output logic               o_busy,
  output logic               o_done,
  output logic [LEN_BW-1:0]  o_out_cnt
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]        o_perf_cycles,
  output logic [31:0]        o_perf_stalls
`endif
);
  localparam int PH_W = $clog2(ROW + COL + 1);
  localparam logic [PH_W-1:0] PH_LOAD_END = PH_W'(COL - 1);
  localparam logic [PH_W-1:0] PH_WAIT_END = PH_W'(ROW + COL - 1);

  state_t             r_state;
  logic [ADDR_BW-1:0] r_w_base, r_x_base;
  logic [LEN_BW-1:0]  r_num_vec;
  logic [1:0]         r_inst;

  logic              w_start, w_exec_rd, w_ph_en, w_ph_clr, w_ph_tc, w_idx_tc;
  logic              w_out_en, w_out_tc, w_drain_end, w_unused;
  logic [PH_W-1:0]   w_ph_cnt, w_ph_term;
  logic [LEN_BW-1:0] w_idx;

  assign w_start   = (r_state == S_IDLE) && i_start;
  assign w_exec_rd = (r_state == S_EXEC) && !i_ofifo_full;
  assign w_ph_en   = (r_state == S_LOAD) || (r_state == S_LWAIT);
  assign w_ph_clr  = w_start || (w_ph_en && w_ph_tc);
  assign w_ph_term = (r_state == S_LOAD) ? PH_LOAD_END : PH_WAIT_END;
  assign w_out_en  = i_valid[COL-1] && ((r_state == S_EXEC) || (r_state == S_DRAIN));
  // Finish on the cycle the last output arrives, not one cycle later.
  assign w_drain_end = w_out_tc || (w_out_en && (o_out_cnt == r_num_vec - LEN_BW'(1)));
  assign w_unused  = ^i_valid[COL-2:0];

  mac_ctrl_counter #(.W(PH_W)) u_phase (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_ph_clr), .i_load(1'b0),
    .i_ld_val('0), .i_en(w_ph_en), .i_term(w_ph_term),
    .o_cnt(w_ph_cnt), .o_tc(w_ph_tc)
  );

  mac_ctrl_counter #(.W(LEN_BW)) u_idx (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_start), .i_load(1'b0),
    .i_ld_val('0), .i_en(w_exec_rd), .i_term(r_num_vec - LEN_BW'(1)),
    .o_cnt(w_idx), .o_tc(w_idx_tc)
  );

  mac_ctrl_counter #(.W(LEN_BW)) u_out (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_start), .i_load(1'b0),
    .i_ld_val('0), .i_en(w_out_en), .i_term(r_num_vec),
    .o_cnt(o_out_cnt), .o_tc(w_out_tc)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_w_base  <= '0;
      r_x_base  <= '0;
      r_num_vec <= '0;
      r_inst    <= INST_IDLE;
    end else begin
      // One-cycle delay lines the instruction up with SRAM read data.
      r_inst <= (r_state == S_LOAD) ? INST_LOAD : (w_exec_rd ? INST_EXEC : INST_IDLE);
      case (r_state)
        S_IDLE: if (i_start) begin
          r_w_base  <= i_w_base;
          r_x_base  <= i_x_base;
          r_num_vec <= i_num_vec;
          r_state   <= S_LOAD;
        end
        S_LOAD:  if (w_ph_tc) r_state <= S_LWAIT;
        S_LWAIT: if (w_ph_tc) r_state <= (r_num_vec == '0) ? S_DRAIN : S_EXEC;
        S_EXEC:  if (w_exec_rd && w_idx_tc) r_state <= S_DRAIN;
        S_DRAIN: if (w_drain_end) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_cen  = !((r_state == S_LOAD) || w_exec_rd);
  assign o_mem_addr = (r_state == S_LOAD) ? r_w_base + ADDR_BW'(w_ph_cnt) :
                      (r_state == S_EXEC) ? r_x_base + ADDR_BW'(w_idx) : '0;
  assign o_inst_w   = r_inst;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_stalls;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_start) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (o_busy) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_EXEC) && i_ofifo_full) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_stalls = r_perf_stalls;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: directed job table, reset-abort sequence, random jobs vs a timeline model.
module tb_mac_array_ctrl;
  localparam int ROW = 8, COL = 8, AB = 11, LB = 8, N = 1024;
  localparam int ESTART = 1 + COL + ROW + COL;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, full = 1'b0;
  logic [AB-1:0] wb = '0, xb = '0;
  logic [LB-1:0] nv = '0;
  logic [COL-1:0] valid = '0;
  logic          cen, busy, done;
  logic [AB-1:0] addr;
  logic [1:0]    inst;
  logic [LB-1:0] ocnt;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0]   pcyc, pstl;
`endif

  mac_array_ctrl #(.ROW(ROW), .COL(COL), .ADDR_BW(AB), .LEN_BW(LB)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_w_base(wb), .i_x_base(xb),
    .i_num_vec(nv), .i_ofifo_full(full), .i_valid(valid),
    .o_mem_cen(cen), .o_mem_addr(addr), .o_inst_w(inst), .o_busy(busy),
    .o_done(done), .o_out_cnt(ocnt)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    , .o_perf_cycles(pcyc), .o_perf_stalls(pstl)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit full_a[N], v7_a[N], rd_ld[N], rd_ex[N];
  logic [AB-1:0] ea[N];
  int D, E, prev_cnt;

  typedef struct {
    logic [AB-1:0] w, x;
    int n, smode, slo, shi;
    bit noise;
    int exp_done;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, t, act, exp);
    end
  endtask

  // Expected timeline from the job rules: which cycles read what, when the job ends.
  task automatic build(input logic [AB-1:0] w, input logic [AB-1:0] x, input int n);
    int t, k, c;
    for (int i = 0; i < N; i++) begin rd_ld[i] = 0; rd_ex[i] = 0; ea[i] = '0; end
    for (int i = 1; i <= COL; i++) begin rd_ld[i] = 1; ea[i] = w + AB'(i - 1); end
    t = ESTART; k = 0;
    while (k < n && t < N - 60) begin
      if (!full_a[t]) begin rd_ex[t] = 1; ea[t] = x + AB'(k); k++; end
      t++;
    end
    E = t; c = 0; D = N - 20;
    for (int tt = ESTART; tt < N - 20; tt++) begin
      c += int'(v7_a[tt]);
      if (tt >= E && c >= n) begin D = tt + 1; break; end
    end
  endtask

  task automatic run_job(input logic [AB-1:0] w, input logic [AB-1:0] x, input int n,
                         input int smode, input int slo, input int shi,
                         input bit vrand, input bit noise, output int obs_d);
    int c, given;
    logic ecen;
    logic [1:0] einst;
    for (int i = 0; i < N; i++) begin full_a[i] = 0; v7_a[i] = 0; end
    if (smode == 1) for (int i = slo; i <= shi; i++) full_a[i] = 1;
    if (smode == 2) for (int i = 0; i < N; i++) full_a[i] = ($urandom_range(3) == 0);
    v7_a[5] = 1; v7_a[20] = 1;
    given = 0;
    if (!vrand) begin
      for (int i = 0; i < n; i++) v7_a[40 + 2 * i] = 1;
    end else begin
      for (int i = 1; i < ESTART; i++) v7_a[i] = ($urandom_range(1) == 0);
      for (int t = ESTART; given < n && t < N - 60; t++)
        if ($urandom_range(2) == 0 || t > 500) begin v7_a[t] = 1; given++; end
    end
    build(w, x, n);
    c = 0; obs_d = -1;
    for (int t = 0; t <= D + 3; t++) begin
      @(posedge clk); #1;
      start = (t == 0) || (noise && t >= 1 && t <= D && $urandom_range(3) == 0);
      if (t == 0) begin wb = w; xb = x; nv = LB'(n); end
      else if (noise && t <= D) begin wb = AB'($urandom); xb = AB'($urandom); nv = LB'($urandom); end
      full  = full_a[t];
      valid = {v7_a[t], (COL-1)'($urandom)};
      #4;
      if (t - 1 >= ESTART && t - 1 <= D - 1) c += int'(v7_a[t - 1]);
      ecen = !(rd_ld[t] || rd_ex[t]);
      einst = (t >= 1 && rd_ld[t-1]) ? 2'b01 : (t >= 1 && rd_ex[t-1]) ? 2'b10 : 2'b00;
      chk("mem_cen", t, 32'(cen), 32'(ecen));
      if (!ecen) chk("mem_addr", t, 32'(addr), 32'(ea[t]));
      chk("inst_w", t, 32'(inst), 32'(einst));
      chk("busy", t, 32'(busy), 32'(t >= 1 && t <= D));
      chk("done", t, 32'(done), 32'(t == D));
      chk("out_cnt", t, 32'(ocnt), (t == 0) ? 32'(prev_cnt) : 32'(c));
      if (done === 1'b1 && obs_d < 0) obs_d = t;
    end
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("perf_cycles", D + 3, pcyc, 32'(D));
    chk("perf_stalls", D + 3, pstl, 32'(E - ESTART - n));
`endif
    prev_cnt = c;
    start = 0; full = 0; valid = '0;
  endtask

  initial begin
    int od;
    tbl[0] = '{11'h010, 11'h040, 4, 0, 0, 0, 1'b0, 47};
    tbl[1] = '{11'h010, 11'h040, 4, 1, 26, 27, 1'b0, 47};
    tbl[2] = '{11'h010, 11'h040, 0, 0, 0, 0, 1'b0, 26};
    tbl[3] = '{11'h7FC, 11'h7FE, 4, 0, 0, 0, 1'b0, 47};
    tbl[4] = '{11'h010, 11'h040, 4, 0, 0, 0, 1'b1, 47};

    repeat (3) @(posedge clk);
    #4;
    chk("rst_cen", 0, 32'(cen), 32'd1);
    chk("rst_addr", 0, 32'(addr), 32'd0);
    chk("rst_inst", 0, 32'(inst), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk("rst_out_cnt", 0, 32'(ocnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    prev_cnt = 0;

    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].w, tbl[i].x, tbl[i].n, tbl[i].smode, tbl[i].slo, tbl[i].shi,
              1'b0, tbl[i].noise, od);
      chk($sformatf("tbl%0d_done_cycle", i), od, 32'(od), 32'(tbl[i].exp_done));
    end

    // Abort mid-LOAD: outputs must drop asynchronously and no done may follow.
    @(posedge clk); #1;
    start = 1; wb = 11'h123; xb = 11'h200; nv = 8'd3;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      start = 0;
    end
    chk("pre_abort_inst", 5, 32'(inst), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_cen", 5, 32'(cen), 32'd1);
    chk("abort_addr", 5, 32'(addr), 32'd0);
    chk("abort_inst", 5, 32'(inst), 32'd0);
    chk("abort_busy", 5, 32'(busy), 32'd0);
    chk("abort_done", 5, 32'(done), 32'd0);
    chk("abort_out_cnt", 5, 32'(ocnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #4;
      chk("post_abort_done", t, 32'(done), 32'd0);
      chk("post_abort_busy", t, 32'(busy), 32'd0);
    end
    prev_cnt = 0;

    for (int j = 0; j < 25; j++)
      run_job(AB'($urandom), AB'($urandom), int'($urandom_range(20)), 2, 0, 0, 1'b1, 1'b1, od);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
